// File: rtl/tube_data_ctrl_pkg.sv
// tube_data_ctrl_pkg: register map, FSM encoding and double-dabble helper shared by the tube controller
package tube_data_ctrl_pkg;
  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_CTRL = 2'd1;
  localparam logic [1:0] REG_STAT = 2'd2;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;
  localparam logic [15:0] DEC_MAX = 16'd9999;
  localparam int ITER = 16;
  localparam int CTRL_EN = 0;
  localparam int CTRL_DEC = 1;
  localparam int STAT_BUSY = 0;
  localparam int STAT_OVF = 1;
  // add 3 to every BCD digit that is 5 or more, ahead of the next left shift
  function automatic logic [15:0] dd_adjust(input logic [15:0] acc);
    logic [15:0] r;
    for (int i = 0; i < 4; i++)
      r[i*4 +: 4] = acc[i*4 +: 4] >= 4'd5 ? acc[i*4 +: 4] + 4'd3 : acc[i*4 +: 4];
    return r;
  endfunction
endpackage

// File: rtl/tube_data_ctrl_bin2bcd_seq.sv
// bin2bcd_seq: sequential 16-bit binary to 4-digit BCD converter (start restarts; done pulses in the commit cycle)
module bin2bcd_seq
  import tube_data_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] value,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd
);
  logic [1:0] state;
  logic [3:0] cnt;
  logic [15:0] sh;
  logic [15:0] acc;
  logic [15:0] adj;
  assign adj = dd_adjust(acc);
  assign busy = state != ST_IDLE;
  assign done = state == ST_COMMIT;
  assign bcd = acc;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt <= '0;
      sh <= '0;
      acc <= '0;
    end else if (start) begin
      state <= ST_SHIFT;
      cnt <= '0;
      sh <= value;
      acc <= '0;
    end else if (state == ST_SHIFT) begin
      acc <= {adj[14:0], sh[15]};
      sh <= {sh[14:0], 1'b0};
      cnt <= cnt + 4'd1;
      if (cnt == 4'(ITER - 1)) state <= ST_COMMIT;
    end else if (state == ST_COMMIT) begin
      state <= ST_IDLE;
    end
  end
endmodule

// File: rtl/tube_data_ctrl.sv
// tube_data_ctrl: bus registers driving a 4-digit tube display in hex or decimal (BCD) mode
module tube_data_ctrl
  import tube_data_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic [15:0] tube_data,
  output logic        tube_en
);
  logic [15:0] data;
  logic [1:0] ctrl;
  logic ovf;
  logic dec, wr_data, wr_ctrl, dec_set, dec_clr, start, eng_done;
  logic [15:0] src, val, bcd;
  logic [31:0] status;
  logic unused_bits;
  assign unused_bits = ^{addr[31:4], addr[1:0], wdata[31:16]};
  assign dec = ctrl[CTRL_DEC];
  assign wr_data = we && addr[3:2] == REG_DATA;
  assign wr_ctrl = we && addr[3:2] == REG_CTRL;
  assign dec_set = wr_ctrl & ~dec & wdata[CTRL_DEC];
  assign dec_clr = wr_ctrl & dec & ~wdata[CTRL_DEC];
  assign start = (wr_data & dec) | dec_set;
  // a DATA write converts the incoming value, a DEC enable converts the stored one
  assign src = wr_data ? wdata[15:0] : data;
  assign val = src > DEC_MAX ? DEC_MAX : src;
  assign tube_en = ctrl[CTRL_EN];
  always_comb begin
    status = '0;
    status[STAT_BUSY] = busy;
    status[STAT_OVF] = ovf;
  end
  assign rdata = addr[3:2] == REG_DATA ? {16'b0, data} :
                 addr[3:2] == REG_CTRL ? {30'b0, ctrl} :
                 addr[3:2] == REG_STAT ? status : 32'b0;
  bin2bcd_seq u_bcd (
    .clk(clk),
    .reset(reset | dec_clr),
    .start(start),
    .value(val),
    .busy(busy),
    .done(eng_done),
    .bcd(bcd)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      data <= '0;
      ctrl <= '0;
      ovf <= 1'b0;
      tube_data <= '0;
    end else begin
      if (wr_data) data <= wdata[15:0];
      if (wr_ctrl) ctrl <= wdata[1:0];
      if (start) ovf <= src > DEC_MAX;
      // a restart landing on the commit cycle discards that result
      if (wr_data & ~dec) tube_data <= wdata[15:0];
      else if (dec_clr) tube_data <= data;
      else if (eng_done & ~start) tube_data <= bcd;
    end
  end
endmodule

// File: tb/tb_tube_data_ctrl.sv
// tb_tube_data_ctrl: directed self-checking bench for tube_data_ctrl
module tb_tube_data_ctrl;
  logic clk = 0;
  logic reset = 1;
  logic we = 0;
  logic [31:0] addr = 0;
  logic [31:0] wdata = 0;
  logic [31:0] rdata;
  logic busy;
  logic [15:0] tube_data;
  logic tube_en;
  int checks = 0;
  int failures = 0;
  tube_data_ctrl dut (
    .clk(clk),
    .reset(reset),
    .we(we),
    .addr(addr),
    .wdata(wdata),
    .rdata(rdata),
    .busy(busy),
    .tube_data(tube_data),
    .tube_en(tube_en)
  );
  always #5 clk = ~clk;
  task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1;
    addr = a;
    wdata = d;
    @(posedge clk);
    #1;
    we = 0;
  endtask
  task rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask
  task edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      edges(1);
    end
  endtask
  int n;
  logic seen;
  initial begin
    we = 1;
    addr = 32'h4;
    wdata = 32'h3;
    edges(2);
    @(negedge clk);
    reset = 0;
    we = 0;
    #1;
    rd("rst_data", 32'h0, 0);
    rd("rst_ctrl", 32'h4, 0);
    rd("rst_stat", 32'h8, 0);
    rd("rst_rsvd", 32'hC, 0);
    chk("rst_en", tube_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tube", tube_data, 0);
    wr(32'h4, 32'h1);
    chk("en_on", tube_en, 1);
    wr(32'h0, 32'h1A2B);
    chk("hex_tube", tube_data, 16'h1A2B);
    chk("hex_busy", busy, 0);
    rd("hex_rd", 32'h0, 32'h1A2B);
    wr(32'hC, 32'hFFFF);
    rd("rsvd_wr", 32'hC, 0);
    wr(32'h4, 32'h3);
    chk("dset_busy", busy, 1);
    edges(16);
    chk("dset_hold", tube_data, 16'h1A2B);
    chk("dset_busy16", busy, 1);
    edges(1);
    chk("dset_tube", tube_data, 16'h6699);
    chk("dset_idle", busy, 0);
    wr(32'h0, 1234);
    rd("stat_busy", 32'h8, 32'h1);
    wait_idle(n);
    chk("dec_cycles", n, 17);
    chk("dec_1234", tube_data, 16'h1234);
    rd("dec_stat", 32'h8, 0);
    wr(32'h0, 50000);
    wait_idle(n);
    chk("ovf_tube", tube_data, 16'h9999);
    rd("ovf_stat", 32'h8, 32'h2);
    rd("ovf_data", 32'h0, 50000);
    wr(32'h0, 7);
    wait_idle(n);
    chk("ovf_clr_tube", tube_data, 16'h0007);
    rd("ovf_clr_stat", 32'h8, 0);
    wr(32'h0, 1111);
    edges(8);
    wr(32'h0, 42);
    seen = 0;
    for (int i = 0; i < 16; i++) begin
      if (tube_data == 16'h1111) seen = 1;
      edges(1);
    end
    chk("abort_hold", tube_data, 16'h0007);
    edges(1);
    chk("abort_tube", tube_data, 16'h0042);
    chk("abort_no1111", seen, 0);
    wr(32'h0, 1234);
    edges(5);
    @(negedge clk);
    reset = 1;
    edges(1);
    reset = 0;
    chk("mrst_tube", tube_data, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_en", tube_en, 0);
    edges(20);
    chk("mrst_nocommit", tube_data, 0);
    rd("mrst_ctrl", 32'h4, 0);
    wr(32'h4, 32'h3);
    wr(32'h0, 50000);
    wait_idle(n);
    chk("ovf2_tube", tube_data, 16'h9999);
    wr(32'h4, 32'h1);
    chk("dclr_idle_tube", tube_data, 16'hC350);
    wr(32'h0, 32'h00FF);
    chk("hex2_tube", tube_data, 16'h00FF);
    rd("hex_ovf_kept", 32'h8, 32'h2);
    wr(32'h4, 32'h3);
    edges(2);
    wr(32'h0, 32'h0ABC);
    edges(3);
    chk("dclr_pre", tube_data, 16'h00FF);
    wr(32'h4, 32'h1);
    chk("dclr_tube", tube_data, 16'h0ABC);
    chk("dclr_busy", busy, 0);
    edges(20);
    chk("dclr_hold", tube_data, 16'h0ABC);
    wr(32'h4, 32'h0);
    chk("en_off", tube_en, 0);
    chk("en_off_tube", tube_data, 16'h0ABC);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
